// File: rtl/multdiv_scoreboard_pkg.sv
// rtl/multdiv_scoreboard_pkg.sv - shared widths and slot record for the mul/div scoreboard
package multdiv_scoreboard_pkg;
  localparam int MD_DEPTH = 17;
  localparam int REG_W    = 5;
  localparam int CNT_W    = 5;

  typedef struct packed {
    logic             valid;
    logic             is_div;
    logic [REG_W-1:0] rd;
  } slot_t;
endpackage

// File: rtl/multdiv_scoreboard_md_slot.sv
// rtl/multdiv_scoreboard_md_slot.sv - one pipeline slot with its RAW comparator
module md_slot
  import multdiv_scoreboard_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  slot_t            slot_in,
  input  logic [REG_W-1:0] rs1_x,
  input  logic [REG_W-1:0] rs2_x,
  output slot_t            slot_out,
  output logic             bp_req
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (shift_en) begin
      slot_d = slot_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // x0 is hardwired, so a write to it never creates a dependency
  assign bp_req = slot_q.valid & (slot_q.rd != '0) &
                  ((slot_q.rd == rs1_x) | (slot_q.rd == rs2_x));
  assign slot_out = slot_q;

endmodule

// File: rtl/multdiv_scoreboard.sv
// rtl/multdiv_scoreboard.sv - fixed-latency mul/div occupancy and RAW scoreboard
module multdiv_scoreboard
  import multdiv_scoreboard_pkg::*;
#(
  parameter int MD_DEPTH = multdiv_scoreboard_pkg::MD_DEPTH,
  parameter int REG_W    = multdiv_scoreboard_pkg::REG_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_is_div,
  input  logic [REG_W-1:0]    issue_rd,
  output logic                issue_ready,
  input  logic [REG_W-1:0]    rs1_x,
  input  logic [REG_W-1:0]    rs2_x,
  input  logic                wb_ready,
  output logic [MD_DEPTH-1:0] busy_stage,
  output logic [MD_DEPTH-1:0] bp_reqX,
  output logic [MD_DEPTH-1:0] exc_piped,
  output logic                wb_valid,
  output logic [REG_W-1:0]    wb_rd,
  output logic                wb_is_div,
  output logic [CNT_W-1:0]    inflight
);

  slot_t            slot_q [MD_DEPTH];
  slot_t            p0_in;
  logic             hold;
  logic             accept;
  logic             retire;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  // A stalled P16 freezes the whole pipe so the fixed latency is preserved
  assign hold        = slot_q[MD_DEPTH-1].valid & ~wb_ready;
  assign issue_ready = ~hold;
  assign accept      = issue_valid & issue_ready;
  assign retire      = slot_q[MD_DEPTH-1].valid & wb_ready;

  always_comb begin
    p0_in = '0;
    if (accept) begin
      p0_in.valid  = 1'b1;
      p0_in.is_div = issue_is_div;
      p0_in.rd     = issue_rd;
    end
  end

  for (genvar i = 0; i < MD_DEPTH; i++) begin : g_slot
    slot_t slot_src;
    if (i == 0) begin : g_head
      assign slot_src = p0_in;
    end else begin : g_body
      assign slot_src = slot_q[i-1];
    end

    md_slot u_slot (
      .clock    (clock),
      .reset    (reset),
      .shift_en (~hold),
      .slot_in  (slot_src),
      .rs1_x    (rs1_x),
      .rs2_x    (rs2_x),
      .slot_out (slot_q[i]),
      .bp_req   (bp_reqX[i])
    );

    assign busy_stage[i] = slot_q[i].valid;
    assign exc_piped[i]  = slot_q[i].valid & slot_q[i].is_div;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, retire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight  = inflight_q;
  assign wb_valid  = slot_q[MD_DEPTH-1].valid;
  assign wb_rd     = slot_q[MD_DEPTH-1].rd;
  assign wb_is_div = slot_q[MD_DEPTH-1].is_div;

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// tb/tb_multdiv_scoreboard.sv - scoreboard bench for multdiv_scoreboard
module tb_multdiv_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_x;
  logic [4:0]  rs2_x;
  logic        wb_ready;
  logic [16:0] busy_stage;
  logic [16:0] bp_reqX;
  logic [16:0] exc_piped;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_is_div;
  logic [4:0]  inflight;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int pos; bit is_div; bit [4:0] rd;} op_t;
  typedef struct {bit is_div; bit [4:0] rd;} exp_t;
  op_t  ops[$];
  op_t  nx[$];
  exp_t exp_q[$];

  multdiv_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .rs1_x        (rs1_x),
    .rs2_x        (rs2_x),
    .wb_ready     (wb_ready),
    .busy_stage   (busy_stage),
    .bp_reqX      (bp_reqX),
    .exc_piped    (exc_piped),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_is_div    (wb_is_div),
    .inflight     (inflight)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_has_wb();
    foreach (ops[i]) if (ops[i].pos == 16) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: every op is a record that advances one position per unheld cycle
  always @(posedge clock) begin
    if (reset) begin
      ops.delete();
      exp_q.delete();
    end else if (!(model_has_wb() && !wb_ready)) begin
      nx.delete();
      foreach (ops[i]) if (ops[i].pos < 16) nx.push_back('{ops[i].pos + 1, ops[i].is_div, ops[i].rd});
      if (issue_valid) begin
        nx.push_back('{0, issue_is_div, issue_rd});
        exp_q.push_back('{issue_is_div, issue_rd});
      end
      ops = nx;
    end
  end

  always @(negedge clock) begin
    logic [16:0] eb, ee, ep;
    bit ewv;
    eb = '0; ee = '0; ep = '0; ewv = 1'b0;
    foreach (ops[i]) begin
      eb[ops[i].pos] = 1'b1;
      if (ops[i].is_div) ee[ops[i].pos] = 1'b1;
      if (ops[i].rd != 0 && (ops[i].rd == rs1_x || ops[i].rd == rs2_x)) ep[ops[i].pos] = 1'b1;
      if (ops[i].pos == 16) ewv = 1'b1;
    end
    check("busy_stage", 32'(busy_stage), 32'(eb));
    check("exc_piped", 32'(exc_piped), 32'(ee));
    check("bp_reqX", 32'(bp_reqX), 32'(ep));
    check("wb_valid", 32'(wb_valid), 32'(ewv));
    check("inflight", 32'(inflight), 32'(ops.size()));
    check("issue_ready", 32'(issue_ready), 32'(!(ewv && !wb_ready)));
  end

  // Monitor: each retiring op must match the oldest accepted issue
  always @(negedge clock) begin
    exp_t e;
    if (wb_valid && wb_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_wb", 32'(wb_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
        check("sb_wb_is_div", 32'(wb_is_div), 32'(e.is_div));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit d, input bit [4:0] r);
    issue_valid = 1'b1; issue_is_div = d; issue_rd = r;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [16:0] frozen;
    bit seen_wb;
    reset = 1'b1; issue_valid = 0; issue_is_div = 0; issue_rd = 0;
    rs1_x = 0; rs2_x = 0; wb_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy_stage), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_issue_ready", 32'(issue_ready), 1);
    check("rst_inflight", 32'(inflight), 0);

    issue(1'b0, 5'd7);
    for (int k = 0; k <= 16; k++) begin
      check("lat_busy", 32'(busy_stage), 32'(1) << k);
      check("lat_wb_valid", 32'(wb_valid), 32'(k == 16));
      if (k == 16) check("lat_wb_rd", 32'(wb_rd), 7);
      tick();
    end
    check("lat_inflight_end", 32'(inflight), 0);
    check("lat_wb_end", 32'(wb_valid), 0);

    do_reset();
    issue(1'b1, 5'd5); tick(); tick(); tick();
    rs1_x = 5; #1;
    check("raw_bp", 32'(bp_reqX), 32'h8);
    check("raw_exc", 32'(exc_piped), 32'h8);
    do_reset();
    rs1_x = 0;
    issue(1'b1, 5'd0); tick(); tick(); tick();
    rs1_x = 5; #1;
    check("raw_rd0_bp", 32'(bp_reqX), 0);
    check("raw_rd0_busy", 32'(busy_stage), 32'h8);
    rs1_x = 0;

    do_reset();
    issue(1'b0, 5'd9); tick(); tick(); tick();
    issue(1'b0, 5'd9); tick(); tick();
    rs2_x = 9; #1;
    check("dup_bp", 32'(bp_reqX), 32'h44);
    rs2_x = 0;

    do_reset();
    issue(1'b0, 5'd3);
    repeat (16) tick();
    check("hold_wb_valid", 32'(wb_valid), 1);
    wb_ready = 1'b0; #1;
    check("hold_issue_ready", 32'(issue_ready), 0);
    frozen = busy_stage;
    for (int j = 0; j < 3; j++) begin
      issue_valid = (j == 1); issue_rd = 5'd11;
      tick();
      check("hold_busy", 32'(busy_stage), 32'(frozen));
      check("hold_inflight", 32'(inflight), 1);
    end
    issue_valid = 1'b0; wb_ready = 1'b1;
    tick();
    check("hold_release_wb", 32'(wb_valid), 0);
    check("hold_release_inflight", 32'(inflight), 0);

    do_reset();
    issue_valid = 1'b1;
    for (int j = 0; j < 17; j++) begin
      issue_is_div = 1'($urandom); issue_rd = 5'($urandom);
      tick();
    end
    check("full_inflight", 32'(inflight), 17);
    check("full_wb_valid", 32'(wb_valid), 1);
    tick();
    check("swap_inflight", 32'(inflight), 17);
    issue_valid = 1'b0;

    do_reset();
    for (int j = 1; j <= 4; j++) issue(1'b1, 5'(j));
    repeat (4) tick();
    rs1_x = 1; rs2_x = 2;
    do_reset();
    check("rstmid_busy", 32'(busy_stage), 0);
    check("rstmid_exc", 32'(exc_piped), 0);
    check("rstmid_bp", 32'(bp_reqX), 0);
    check("rstmid_wb_rd", 32'(wb_rd), 0);
    check("rstmid_issue_ready", 32'(issue_ready), 1);
    check("rstmid_inflight", 32'(inflight), 0);
    seen_wb = 1'b0;
    repeat (20) begin
      tick();
      if (wb_valid) seen_wb = 1'b1;
    end
    check("rstmid_no_wb", 32'(seen_wb), 0);

    for (int c = 0; c < 600; c++) begin
      issue_valid  = ($urandom_range(0, 99) < 60);
      issue_is_div = 1'($urandom);
      issue_rd     = 5'($urandom_range(0, 7));
      rs1_x        = 5'($urandom_range(0, 7));
      rs2_x        = 5'($urandom_range(0, 7));
      wb_ready     = ($urandom_range(0, 99) < 70);
      reset        = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; issue_valid = 1'b0; wb_ready = 1'b1;
    repeat (20) tick();
    check("drain_inflight", 32'(inflight), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_scoreboard.md
MULTDIV_SCOREBOARD -- requirements
Module: multdiv_scoreboard

Interface
REQ-001 SHALL have parameter MD_DEPTH, default 17; number of multiply/divide pipeline slots P0..P16.
REQ-002 SHALL have parameter REG_W, default 5; register-number width.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port issue_valid, input, 1: a mul/div leaves D.X this cycle.
REQ-006 SHALL have port issue_is_div, input, 1: 1 = div, 0 = mul.
REQ-007 SHALL have port issue_rd, input, REG_W: destination register of the issued op.
REQ-008 SHALL have port issue_ready, output, 1: slot P0 can accept an issue this cycle.
REQ-009 SHALL have port rs1_x, input, REG_W: first source register of the instruction in X.
REQ-010 SHALL have port rs2_x, input, REG_W: second source register of the instruction in X.
REQ-011 SHALL have port wb_ready, input, 1: M.W can take the completed result this cycle.
REQ-012 SHALL have port busy_stage, output, MD_DEPTH: per-slot occupancy.
REQ-013 SHALL have port bp_reqX, output, MD_DEPTH: per-slot RAW hit against rs1_x/rs2_x.
REQ-014 SHALL have port exc_piped, output, MD_DEPTH: per-slot occupied-by-div (may raise an exception).
REQ-015 SHALL have port wb_valid, output, 1: slot P16 holds a completed op.
REQ-016 SHALL have port wb_rd, output, REG_W: destination register of the P16 op.
REQ-017 SHALL have port wb_is_div, output, 1: op type of the P16 op.
REQ-018 SHALL have port inflight, output, 5: count of occupied slots, 0..17.

Function
REQ-019 SHALL hold per-slot state {valid, is_div, rd}; busy_stage[i] = valid[i]; exc_piped[i] = valid[i] & is_div[i].
REQ-020 SHALL define hold = valid[16] & ~wb_ready; while hold is 1, every slot keeps its contents.
REQ-021 SHALL, when hold = 0, shift slot i into slot i+1 for i = 0..15 and retire slot 16 (valid[16] cleared unless refilled by slot 15).
REQ-022 SHALL drive issue_ready = ~hold, combinationally.
REQ-023 SHALL load P0 with {1, issue_is_div, issue_rd} when issue_valid & issue_ready; otherwise P0 becomes invalid when hold = 0.
REQ-024 SHALL ignore issue_valid while issue_ready = 0; slot contents and inflight are unchanged.
REQ-025 SHALL fix latency: an op issued in cycle N with no hold appears with wb_valid = 1 in cycle N+16 and retires at the end of that cycle if wb_ready = 1.
REQ-026 SHALL compute bp_reqX[i] = valid[i] & (rd[i] != 0) & ((rd[i] == rs1_x) | (rd[i] == rs2_x)), combinationally, from current-cycle state only.
REQ-027 SHALL never assert bp_reqX for rd = 0; the slot is still tracked in busy_stage and inflight.
REQ-028 SHALL update inflight by +1 on an accepted issue and -1 on a retire (valid[16] & wb_ready); a simultaneous issue and retire SHALL leave it unchanged.
REQ-029 SHALL drive wb_valid = valid[16], wb_rd = rd[16], wb_is_div = is_div[16].
REQ-030 SHALL allow multiple slots to hold the same rd; bp_reqX reports every matching slot independently.

Reset
REQ-031 SHALL, while reset = 1 at a clock edge, clear every valid, is_div and rd to 0 and set inflight to 0, overriding any issue, hold or retire in the same cycle.
REQ-032 SHALL drive, in the cycle after reset: busy_stage, bp_reqX and exc_piped = 0, wb_valid = 0, wb_rd = 0, and issue_ready = 1.
REQ-033 SHALL discard all in-flight ops on a reset asserted mid-operation; no wb_valid is produced for them.

Structure
REQ-034 SHALL place MD_DEPTH, REG_W and the slot record type {valid, is_div, rd} in the shared processor package.
REQ-035 SHALL implement one slot as sub-module md_slot (registered slot plus its RAW comparator), instantiated MD_DEPTH times in a generate loop.

Verification
REQ-036 SHALL cover latency: issue a mul with rd = 7 at cycle 0 and wb_ready = 1 throughout -> busy_stage = 1<<k at cycle k; wb_valid = 1 with wb_rd = 7 at cycle 16 only; inflight returns to 0 at cycle 17.
REQ-037 SHALL cover RAW detection: a div with rd = 5 in P3, and rs1_x = 5 -> bp_reqX = 0x00008 and exc_piped = 0x00008; with rs1_x = 5 but rd = 0 in that slot -> bp_reqX = 0.
REQ-038 SHALL cover hold: P16 valid with wb_ready = 0 for 3 cycles -> all slots frozen, issue_ready = 0, and an issue_valid pulse is ignored (inflight unchanged); on wb_ready = 1 the retire and shift occur.
REQ-039 SHALL cover simultaneous issue and retire: 17 back-to-back issues with inflight = 17 -> inflight stays 17 across an issue-plus-retire cycle.
REQ-040 SHALL cover reset mid-operation: reset at cycle 8 after 4 issues -> all outputs 0 next cycle, issue_ready = 1, and no later wb_valid.
REQ-041 SHALL cover duplicate destinations: two muls with rd = 9 in P2 and P6, and rs2_x = 9 -> bp_reqX = 0x00044.
